// File: rtl/chan_sched_pkg.sv
// chan_sched_pkg: shared FSM state, channel index type and channel limit for chan_scheduler
package chan_sched_pkg;

    localparam int N_CH_MAX = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/chan_scheduler.sv
// chan_scheduler: time-multiplexes one single-channel core over N_CH sample channels per frame.
// Optional watchdog bypass enabled by defining CHAN_SCHED_WATCHDOG_EN.
module chan_scheduler
    import chan_sched_pkg::*;
#(
    parameter int W           = 16,
    parameter int N_CH        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_clk,
    input  logic [W-1:0] sample_in0,
    input  logic [W-1:0] sample_in1,
    input  logic [W-1:0] sample_in2,
    input  logic [W-1:0] sample_in3,
    output logic [W-1:0] sample_out0,
    output logic [W-1:0] sample_out1,
    output logic [W-1:0] sample_out2,
    output logic [W-1:0] sample_out3,
    output logic         core_in_valid,
    input  logic         core_in_ready,
    output logic [W-1:0] core_in_data,
    output logic [1:0]   core_in_ch,
    input  logic         core_out_valid,
    output logic         core_out_ready,
    input  logic [W-1:0] core_out_data,
    output logic         busy,
    output logic         overrun,
    output logic         timeout
);

    state_t       state;
    ch_t          ch;
    logic         sample_clk_q;
    logic         frame_edge;
    logic         wd_fire;
    logic         done;
    logic [W-1:0] res_val;
    logic [W-1:0] din  [N_CH_MAX];
    logic [W-1:0] snap [N_CH_MAX];
    logic [W-1:0] res  [N_CH_MAX];
    logic [W-1:0] outq [N_CH_MAX];

    assign din[0] = sample_in0;
    assign din[1] = sample_in1;
    assign din[2] = sample_in2;
    assign din[3] = sample_in3;

    assign sample_out0 = outq[0];
    assign sample_out1 = outq[1];
    assign sample_out2 = outq[2];
    assign sample_out3 = outq[3];

    assign frame_edge     = sample_clk & ~sample_clk_q;
    assign busy           = state != IDLE;
    assign core_in_valid  = state == ISSUE;
    assign core_out_ready = state == WAIT;
    assign core_in_data   = snap[ch];
    assign core_in_ch     = ch;
    // A watchdog expiry stands in for a core result, carrying the unprocessed snapshot through.
    assign done           = (state == WAIT) && (core_out_valid || wd_fire);
    assign res_val        = core_out_valid ? core_out_data : snap[ch];

`ifdef CHAN_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wd_cnt;

    assign wd_fire = (state == WAIT) && !core_out_valid && (wd_cnt == CW'(TIMEOUT_CYC - 1));

    // Count cycles spent in WAIT; the count restarts at zero on every WAIT entry, timeout is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
            if (wd_fire)
                timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    // Frame FSM: snapshot on edge, issue/collect each channel, then commit all outputs together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ch           <= '0;
            sample_clk_q <= 1'b1;
            overrun      <= 1'b0;
            for (int i = 0; i < N_CH_MAX; i++) begin
                snap[i] <= '0;
                res[i]  <= '0;
                outq[i] <= '0;
            end
        end else begin
            sample_clk_q <= sample_clk;
            overrun      <= frame_edge && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_edge) begin
                        for (int i = 0; i < N_CH_MAX; i++)
                            if (i < N_CH)
                                snap[i] <= din[i];
                        ch    <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (core_in_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        res[ch] <= res_val;
                        if (ch == ch_t'(N_CH - 1)) begin
                            state <= COMMIT;
                        end else begin
                            ch    <= ch_t'(ch + 1'b1);
                            state <= ISSUE;
                        end
                    end
                end
                default: begin
                    for (int i = 0; i < N_CH_MAX; i++)
                        if (i < N_CH)
                            outq[i] <= res[i];
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chan_scheduler.sv
// tb_chan_scheduler: directed-vector bench for chan_scheduler with an echo(+1) core model.
// Define CHAN_SCHED_WATCHDOG_EN to also exercise the watchdog bypass with TIMEOUT_CYC=16.
module tb_chan_scheduler;

    localparam int W = 16;
`ifdef CHAN_SCHED_WATCHDOG_EN
    localparam int TCYC = 16;
`else
    localparam int TCYC = 1024;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_clk = 1'b0;
    logic [W-1:0] sample_in0 = '0, sample_in1 = '0, sample_in2 = '0, sample_in3 = '0;
    logic [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic         core_in_valid, core_in_ready, core_out_valid, core_out_ready;
    logic [W-1:0] core_in_data, core_out_data;
    logic [1:0]   core_in_ch;
    logic         busy, overrun, timeout;

    logic         core_en = 1'b1;
    logic         pend;
    logic [W-1:0] pdata;

    int vectors = 0;
    int errors  = 0;

    chan_scheduler #(.W(W), .N_CH(4), .TIMEOUT_CYC(TCYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_clk    (sample_clk),
        .sample_in0    (sample_in0),
        .sample_in1    (sample_in1),
        .sample_in2    (sample_in2),
        .sample_in3    (sample_in3),
        .sample_out0   (sample_out0),
        .sample_out1   (sample_out1),
        .sample_out2   (sample_out2),
        .sample_out3   (sample_out3),
        .core_in_valid (core_in_valid),
        .core_in_ready (core_in_ready),
        .core_in_data  (core_in_data),
        .core_in_ch    (core_in_ch),
        .core_out_valid(core_out_valid),
        .core_out_ready(core_out_ready),
        .core_out_data (core_out_data),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    // Core model: returns input+1 one cycle after accepting it, unless disabled.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            pdata <= '0;
        end else if (core_in_valid && core_in_ready) begin
            pend  <= 1'b1;
            pdata <= core_in_data + 1'b1;
        end else if (core_out_valid && core_out_ready) begin
            pend <= 1'b0;
        end
    end

    assign core_out_valid = pend && core_en;
    assign core_out_data  = pdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input int a, input int b, input int c, input int d);
        sample_in0 = W'(a);
        sample_in1 = W'(b);
        sample_in2 = W'(c);
        sample_in3 = W'(d);
    endtask

    initial begin
        core_in_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out0", sample_out0, 0);
        check("rst_busy", busy, 0);
        check("rst_vld", core_in_valid, 0);
        check("rst_ordy", core_out_ready, 0);
        check("rst_ovr", overrun, 0);
        check("rst_tmo", timeout, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: basic frame, 9-cycle latency, channel order 0..3
        set_in(100, 200, 300, 400);
        sample_clk = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) sample_clk = 1'b0;
            if (k == 1 || k == 3 || k == 5 || k == 7) begin
                check("t1_vld", core_in_valid, 1);
                check("t1_ch", core_in_ch, (k - 1) / 2);
                check("t1_data", core_in_data, 100 * ((k + 1) / 2));
            end
            if (k == 9) check("t1_early", sample_out0, 0);
        end
        check("t1_out0", sample_out0, 101);
        check("t1_out1", sample_out1, 201);
        check("t1_out2", sample_out2, 301);
        check("t1_out3", sample_out3, 401);
        check("t1_busy", busy, 0);

        // 2: backpressure on ch1 for 5 cycles
        set_in(10, 20, 30, 40);
        sample_clk = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 2) begin
                sample_clk = 1'b0;
                core_in_ready = 1'b0;
            end
            if (k >= 3 && k <= 7) begin
                check("t2_vld", core_in_valid, 1);
                check("t2_ch", core_in_ch, 1);
                check("t2_data", core_in_data, 20);
            end
            if (k == 8) core_in_ready = 1'b1;
            if (k == 14) check("t2_early", sample_out0, 101);
        end
        check("t2_out0", sample_out0, 11);
        check("t2_out3", sample_out3, 41);

        // 3: second edge while busy -> overrun, dropped
        set_in(1, 2, 3, 4);
        sample_clk = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) sample_clk = 1'b0;
            if (k == 4) begin
                check("t3_ovr_pre", overrun, 0);
                set_in(7, 8, 9, 10);
                sample_clk = 1'b1;
            end
            if (k == 5) check("t3_ovr", overrun, 1);
            if (k == 6) begin
                check("t3_ovr_post", overrun, 0);
                sample_clk = 1'b0;
            end
            if (k == 10) begin
                check("t3_out0", sample_out0, 2);
                check("t3_out3", sample_out3, 5);
            end
        end
        check("t3_busy", busy, 0);
        check("t3_hold", sample_out1, 3);

        // 4: reset during WAIT on ch2
        set_in(50, 60, 70, 80);
        sample_clk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) sample_clk = 1'b0;
        end
        check("t4_ordy", core_out_ready, 1);
        check("t4_ch", core_in_ch, 2);
        rst_n = 1'b0;
        #1;
        check("t4_busy", busy, 0);
        check("t4_out0", sample_out0, 0);
        check("t4_out2", sample_out2, 0);
        check("t4_ordy0", core_out_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_in(5, 6, 7, 8);
        sample_clk = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) sample_clk = 1'b0;
        end
        check("t4_new0", sample_out0, 6);
        check("t4_new3", sample_out3, 9);

        // 6: sample_clk high through reset release -> no frame
        sample_clk = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_vld", core_in_valid, 0);
        sample_clk = 1'b0;
        @(negedge clk);
        sample_clk = 1'b1;
        @(negedge clk);
        check("t6_start", busy, 1);
        sample_clk = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_done", busy, 0);

`ifdef CHAN_SCHED_WATCHDOG_EN
        // 5: core never answers -> watchdog bypass per channel
        core_en = 1'b0;
        set_in(11, 22, 33, 44);
        sample_clk = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 2) sample_clk = 1'b0;
            if (k == 17) begin
                check("t5_tmo_pre", timeout, 0);
                check("t5_ch0", core_in_ch, 0);
            end
            if (k == 18) begin
                check("t5_tmo", timeout, 1);
                check("t5_vld", core_in_valid, 1);
                check("t5_ch1", core_in_ch, 1);
            end
        end
        check("t5_out0", sample_out0, 11);
        check("t5_out3", sample_out3, 44);
        check("t5_busy", busy, 0);
`else
        check("t5_tmo_tied", timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
